// File: rtl/led_pkg.sv
//------------------------------------------------------------------------------
// Module : led_pkg
// Brief  : Mode and FSM state encodings shared by the LED sequencer slice.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package led_pkg;

  localparam int DEF_NUM_LEDS = 5;

  localparam logic [1:0] MODE_BLINK  = 2'd0;
  localparam logic [1:0] MODE_CHASE  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_COUNT  = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/led_tick_prescaler.sv
//------------------------------------------------------------------------------
// Module : led_tick_prescaler
// Brief  : Counts 0..DIV-1 while enabled; tick is high on the DIV-1 count.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module led_tick_prescaler #(
  parameter int DIV = 1000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] c_last = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = en && (r_cnt == c_last);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (tick) r_cnt <= '0;
      else      r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_sequencer.sv
//------------------------------------------------------------------------------
// Module : led_sequencer
// Brief  : Runs the LED bank through blink/chase/bounce/count patterns for a
//          latched number of steps, with start/stop handshake.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module led_sequencer
  import led_pkg::*;
#(
  parameter int NUM_LEDS  = DEF_NUM_LEDS,
  parameter int TICK_DIV  = 1000000,
  parameter int STEP_BITS = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [1:0]           mode,
  input  logic [STEP_BITS-1:0] steps,
  input  logic                 start,
  input  logic                 stop,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_LEDS-1:0]  leds
);

  localparam logic [NUM_LEDS-1:0]  c_led_one  = {{(NUM_LEDS-1){1'b0}}, 1'b1};
  localparam logic [STEP_BITS-1:0] c_step_one = {{(STEP_BITS-1){1'b0}}, 1'b1};

  logic [0:0]           r_state;
  logic [0:0]           w_state_next;
  logic [1:0]           r_mode;
  logic [STEP_BITS-1:0] r_steps;
  logic [STEP_BITS-1:0] r_step_cnt;
  logic [STEP_BITS-1:0] w_step_inc;
  logic [NUM_LEDS-1:0]  r_leds;
  logic [NUM_LEDS-1:0]  w_leds_next;
  logic [NUM_LEDS-1:0]  w_pat_next;
  logic [NUM_LEDS-1:0]  w_pat_init;
  logic                 r_dir;
  logic                 w_dir_next;
  logic                 r_done;
  logic                 w_done_next;
  logic                 w_tick;
  logic                 w_start_acc;
  logic                 w_last;

  led_tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .resetn (resetn),
    .en     (r_state == ST_RUN),
    .clr    (r_state == ST_IDLE),
    .tick   (w_tick)
  );

  assign w_start_acc = (r_state == ST_IDLE) && start && !stop;
  assign w_step_inc  = r_step_cnt + c_step_one;
  // steps == 0 means free-running, so the counter wrap must never end a run
  assign w_last      = w_tick && (r_steps != '0) && (w_step_inc == r_steps);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start && !stop)   w_state_next = ST_RUN;
      ST_RUN:  if (stop || w_last)   w_state_next = ST_IDLE;
      default:                       w_state_next = ST_IDLE;
    endcase
  end

  // Output logic: next pattern value and registered-output next values
  always_comb begin
    w_pat_next = r_leds;
    w_dir_next = r_dir;
    case (r_mode)
      MODE_BLINK: w_pat_next = ~r_leds;
      MODE_CHASE: w_pat_next = {r_leds[NUM_LEDS-2:0], r_leds[NUM_LEDS-1]};
      MODE_BOUNCE: begin
        if (r_dir) begin
          if (r_leds[NUM_LEDS-1]) begin
            w_pat_next = r_leds >> 1;
            w_dir_next = 1'b0;
          end else begin
            w_pat_next = r_leds << 1;
          end
        end else begin
          if (r_leds[0]) begin
            w_pat_next = r_leds << 1;
            w_dir_next = 1'b1;
          end else begin
            w_pat_next = r_leds >> 1;
          end
        end
      end
      MODE_COUNT: w_pat_next = r_leds + c_led_one;
      default:    w_pat_next = r_leds;
    endcase

    case (mode)
      MODE_BLINK: w_pat_init = '1;
      MODE_COUNT: w_pat_init = '0;
      default:    w_pat_init = c_led_one;
    endcase

    w_leds_next = r_leds;
    w_done_next = 1'b0;
    case (r_state)
      ST_IDLE: w_leds_next = w_start_acc ? w_pat_init : '0;
      ST_RUN: begin
        w_done_next = stop || w_last;
        if (stop)        w_leds_next = '0;
        else if (w_tick) w_leds_next = w_pat_next;
      end
      default: w_leds_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_leds     <= '0;
      r_done     <= 1'b0;
      r_mode     <= MODE_BLINK;
      r_steps    <= '0;
      r_step_cnt <= '0;
      r_dir      <= 1'b1;
    end else begin
      r_leds <= w_leds_next;
      r_done <= w_done_next;
      if (w_start_acc) begin
        r_mode     <= mode;
        r_steps    <= steps;
        r_step_cnt <= '0;
        r_dir      <= 1'b1;
      end else if ((r_state == ST_RUN) && w_tick) begin
        r_step_cnt <= w_step_inc;
        r_dir      <= w_dir_next;
      end
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = r_done;
  assign leds = r_leds;

endmodule

`default_nettype wire

// File: tb/tb_led_sequencer.sv
//------------------------------------------------------------------------------
// Module : tb_led_sequencer
// Brief  : Directed and randomized runs of led_sequencer against a pattern model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] mode;
  logic [7:0] steps;
  logic       start;
  logic       stop;
  logic       busy;
  logic       done;
  logic [4:0] leds;

  int passed = 0;
  int total  = 0;

  led_sequencer #(
    .NUM_LEDS  (5),
    .TICK_DIV  (4),
    .STEP_BITS (8)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .mode   (mode),
    .steps  (steps),
    .start  (start),
    .stop   (stop),
    .busy   (busy),
    .done   (done),
    .leds   (leds)
  );

  always #5 clk = ~clk;

  // Pattern value after k steps, derived directly from each mode's rule
  function automatic logic [4:0] pat(input int m, input int k);
    int p;
    case (m)
      0: return (k % 2 == 0) ? 5'b11111 : 5'b00000;
      1: return 5'(1 << (k % 5));
      2: begin
        p = k % 8;
        if (p > 4) p = 8 - p;
        return 5'(1 << p);
      end
      default: return 5'(k % 32);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Start a run; finish on completion or by stop after stop_after ticks
  task automatic do_run(input int m, input int st, input int stop_after);
    int k;
    start = 1'b1; mode = m[1:0]; steps = st[7:0]; stop = 1'b0;
    cyc();
    start = 1'b0; mode = 2'($urandom); steps = 8'($urandom);
    check("busy_rise", {31'd0, busy}, 32'd1);
    check("init_leds", {27'd0, leds}, {27'd0, pat(m, 0)});
    check("init_done", {31'd0, done}, 32'd0);
    for (k = 1; k <= 200; k++) begin
      for (int c = 0; c < 3; c++) begin
        if (c == 0) begin
          start = 1'b1;
          mode  = 2'($urandom);
          steps = 8'($urandom);
        end else begin
          start = 1'b0;
        end
        cyc();
        check("hold_leds", {27'd0, leds}, {27'd0, pat(m, k - 1)});
      end
      start = 1'b0;
      cyc();
      if (st != 0 && k == st) begin
        check("end_done", {31'd0, done}, 32'd1);
        check("end_busy", {31'd0, busy}, 32'd0);
        check("end_leds", {27'd0, leds}, {27'd0, pat(m, k)});
        cyc();
        check("post_leds", {27'd0, leds}, 32'd0);
        check("post_done", {31'd0, done}, 32'd0);
        check("post_busy", {31'd0, busy}, 32'd0);
        return;
      end
      check("step_leds", {27'd0, leds}, {27'd0, pat(m, k)});
      check("step_busy", {31'd0, busy}, 32'd1);
      check("step_done", {31'd0, done}, 32'd0);
      if (stop_after != 0 && k == stop_after) begin
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("stop_done", {31'd0, done}, 32'd1);
        check("stop_leds", {27'd0, leds}, 32'd0);
        check("stop_busy", {31'd0, busy}, 32'd0);
        cyc();
        check("stop_done_clr", {31'd0, done}, 32'd0);
        return;
      end
    end
    check("run_bound", 32'(k), 32'(st));
  endtask

  initial begin
    resetn = 1'b0; start = 1'b1; stop = 1'b0; mode = 2'd1; steps = 8'd3;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("rst_leds", {27'd0, leds}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
    end
    start = 1'b0;
    resetn = 1'b1;
    cyc();

    do_run(1, 6, 0);
    do_run(2, 0, 9);
    do_run(3, 40, 0);

    // start and stop together while idle
    start = 1'b1; stop = 1'b1; mode = 2'd1; steps = 8'd2;
    cyc();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", {31'd0, busy}, 32'd0);
    check("ss_done", {31'd0, done}, 32'd0);
    check("ss_leds", {27'd0, leds}, 32'd0);
    cyc();
    check("ss_done2", {31'd0, done}, 32'd0);

    // stop while idle is a no-op
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("idle_stop_done", {31'd0, done}, 32'd0);

    for (int r = 0; r < 4; r++) begin
      do_run(int'($urandom_range(0, 3)), int'($urandom_range(1, 12)), 0);
    end
    do_run(int'($urandom_range(0, 3)), 0, int'($urandom_range(1, 10)));

    // reset during a blink run
    start = 1'b1; mode = 2'd0; steps = 8'd0;
    cyc();
    start = 1'b0;
    repeat (8) cyc();
    check("blink_k2", {27'd0, leds}, {27'd0, pat(0, 2)});
    resetn = 1'b0;
    #1;
    check("arst_leds", {27'd0, leds}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    cyc();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rel_done", {31'd0, done}, 32'd0);
      check("rel_leds", {27'd0, leds}, 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
